pipe_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the execute stage. It handles logical-left, logical-right, arithmetic-right and rotate-left operations on an XLEN-bit operand. The logarithmic shift network is split across STAGES register stages, with valid/ready handshakes on both sides. A pass-through tag lets the pipeline match results to destination registers, and a flush input kills in-flight operations on branch mispredict.

---
 rtl/pipe_shifter.sv | 158 +++++++++++++++
 tb/tb_pipe_shifter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL over log2(XLEN) shift layers
// split across STAGES register stages, valid/ready on both sides,
// pass-through tag and a flush that kills everything in flight.
module pipe_shifter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_shamt,
  input  logic [1:0]       i_op,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned LOG = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  if ((XLEN & (XLEN - 1)) != 0 || XLEN < 8 || XLEN > 64) begin : g_bad_xlen
    $error("pipe_shifter: XLEN must be a power of two in 8..64");
  end
  if (STAGES < 1 || STAGES > LOG) begin : g_bad_stages
    $error("pipe_shifter: STAGES must be in 1..log2(XLEN)");
  end

  // One shift layer by a power-of-two distance; sgn is the operand's original MSB.
  function automatic logic [XLEN-1:0] shift_layer(input logic [XLEN-1:0] v,
                                                  input op_e op,
                                                  input logic sgn,
                                                  input int unsigned sh);
    logic [XLEN-1:0] fill;
    logic [XLEN-1:0] r;
    fill = sgn ? ~({XLEN{1'b1}} >> sh) : '0;
    case (op)
      OP_SLL:  r = v << sh;
      OP_SRL:  r = v >> sh;
      OP_SRA:  r = (v >> sh) | fill;
      default: r = (v << sh) | (v >> (XLEN - sh));
    endcase
    return r;
  endfunction

  // Stage registers
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] sgn_q;
  logic [XLEN-1:0]   val_q [STAGES];
  logic [LOG-1:0]    sh_q  [STAGES];
  op_e               op_q  [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  // Stage inputs and per-stage combinational results
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] in_vld;
  logic [STAGES-1:0] in_sgn;
  logic [XLEN-1:0]   in_val  [STAGES];
  logic [XLEN-1:0]   nxt_val [STAGES];
  logic [LOG-1:0]    in_sh   [STAGES];
  op_e               in_op   [STAGES];
  logic [TAG_W-1:0]  in_tag  [STAGES];

  logic unused_shamt_hi;
  assign unused_shamt_hi = ^i_shamt[XLEN-1:LOG];

  // Route each stage's input: stage 0 from the ports, later stages from the previous register.
  always_comb begin
    in_vld[0] = i_valid;
    in_sgn[0] = i_a[XLEN-1];
    in_val[0] = i_a;
    in_sh[0]  = i_shamt[LOG-1:0];
    in_op[0]  = op_e'(i_op);
    in_tag[0] = i_tag;
    for (int unsigned k = 1; k < STAGES; k++) begin
      in_vld[k] = vld_q[k-1];
      in_sgn[k] = sgn_q[k-1];
      in_val[k] = val_q[k-1];
      in_sh[k]  = sh_q[k-1];
      in_op[k]  = op_q[k-1];
      in_tag[k] = tag_q[k-1];
    end
  end

  // Stage k may load when any stage from k to the output has a hole, or the consumer takes the output.
  // This is the unrolled form of "empty or downstream advances".
  always_comb begin
    adv = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      logic full;
      full = 1'b1;
      for (int unsigned j = k; j < STAGES; j++) begin
        full = full & vld_q[j];
      end
      adv[k] = i_ready | ~full;
    end
  end

  // Apply the contiguous block of layers each stage owns (LSB layers first).
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      logic [XLEN-1:0] v;
      v = in_val[k];
      for (int unsigned j = 0; j < LOG; j++) begin
        if (j >= (k * LOG) / STAGES && j < ((k + 1) * LOG) / STAGES && in_sh[k][j]) begin
          v = shift_layer(v, in_op[k], in_sgn[k], 32'd1 << j);
        end
      end
      nxt_val[k] = v;
    end
  end

  // Pipeline registers; flush clears every valid bit but lets the datapath load freely.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      sgn_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        val_q[k] <= '0;
        sh_q[k]  <= '0;
        op_q[k]  <= OP_SLL;
        tag_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (i_flush) begin
          vld_q[k] <= 1'b0;
        end else if (adv[k]) begin
          vld_q[k] <= in_vld[k];
        end
        if (adv[k]) begin
          sgn_q[k] <= in_sgn[k];
          val_q[k] <= nxt_val[k];
          sh_q[k]  <= in_sh[k];
          op_q[k]  <= in_op[k];
          tag_q[k] <= in_tag[k];
        end
      end
    end
  end

  assign o_ready  = adv[0];
  assign o_valid  = vld_q[STAGES-1];
  assign o_result = val_q[STAGES-1];
  assign o_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter at XLEN=32 with STAGES=1, 2 and 5 in parallel.
module tb_pipe_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;

  task automatic chk(input int st, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL st%0d %s actual=%h required=%h", st, name, act, exp);
    end
  endtask

  // Reference: plain shift/rotate arithmetic on the masked amount.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] sh, input logic [1:0] op);
    int unsigned s;
    logic [63:0] d;
    logic [31:0] r;
    s = int'(sh[4:0]);
    d = {a, a} << s;
    case (op)
      SLL:     r = a << s;
      SRL:     r = a >> s;
      SRA:     r = 32'($signed(a) >>> s);
      default: r = d[63:32];
    endcase
    return r;
  endfunction

  // Directed vectors: {a, shamt, op, expected}
  function automatic logic [97:0] dvec(input int i);
    case (i)
      0:       return {32'h8000_0001, 32'd1,         SLL, 32'h0000_0002};
      1:       return {32'h8000_0001, 32'd4,         ROL, 32'h0000_0018};
      2:       return {32'h8000_0000, 32'd31,        SRA, 32'hFFFF_FFFF};
      3:       return {32'h8000_0000, 32'd31,        SRL, 32'h0000_0001};
      4:       return {32'h7FFF_FFFF, 32'd31,        SRA, 32'h0000_0000};
      5:       return {32'h0000_0001, 32'h25,        SLL, 32'h0000_0020};
      6:       return {32'hA5A5_5A5A, 32'd0,         SLL, 32'hA5A5_5A5A};
      7:       return {32'hA5A5_5A5A, 32'd0,         SRL, 32'hA5A5_5A5A};
      8:       return {32'hA5A5_5A5A, 32'd0,         SRA, 32'hA5A5_5A5A};
      9:       return {32'hA5A5_5A5A, 32'd0,         ROL, 32'hA5A5_5A5A};
      10:      return {32'h8000_0000, 32'hFFFF_FFE4, SRA, 32'hF800_0000};
      11:      return {32'h1234_5678, 32'h10,        ROL, 32'h5678_1234};
      12:      return {32'hF000_0000, 32'h3F,        ROL, 32'h7800_0000};
      default: return {32'h0000_0001, 32'd31,        SRA, 32'h0000_0000};
    endcase
  endfunction

  localparam int NVEC = 14;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int ST = (g == 0) ? 1 : ((g == 1) ? 2 : 5);

    logic        rst     = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_a     = '0;
    logic [31:0] i_shamt = '0;
    logic [1:0]  i_op    = '0;
    logic [4:0]  i_tag   = '0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_tag;

    logic [36:0] q[$];

    pipe_shifter #(.XLEN(32), .STAGES(ST), .TAG_W(5)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_shamt (i_shamt),
      .i_op    (i_op),
      .i_tag   (i_tag),
      .i_flush (i_flush),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_result(o_result),
      .o_tag   (o_tag)
    );

    // Monitor: every output handshake pops and compares the oldest expected entry.
    always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk(ST, "unexpected_output", {27'd0, o_tag, o_result}, 64'hDEAD);
        end else begin
          logic [36:0] e;
          e = q.pop_front();
          chk(ST, "result_tag", {27'd0, o_tag, o_result}, {27'd0, e});
        end
      end
    end

    // Drive one cycle starting just after a rising edge; record accepts in the scoreboard.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] sh,
                         input logic [1:0] op, input logic [4:0] tag, input logic rdy,
                         input logic fl, input logic [36:0] exp, output logic acc);
      i_valid = v; i_a = a; i_shamt = sh; i_op = op; i_tag = tag;
      i_ready = rdy; i_flush = fl;
      @(negedge clk); #1;
      acc = v && o_ready && !fl && !rst;
      if (rst || fl) q.delete();
      else if (acc) q.push_back(exp);
      @(posedge clk); #1;
    endtask

    task automatic idle(input logic rdy);
      logic acc;
      cycle(1'b0, '0, '0, SLL, '0, rdy, 1'b0, '0, acc);
    endtask

    task automatic drain();
      for (int n = 0; n < 40 && q.size() != 0; n++) idle(1'b1);
      chk(ST, "drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Fill the pipeline while the consumer stalls; returns how many were accepted.
    task automatic fill(input int base, output int nacc);
      logic acc;
      logic [4:0] t;
      nacc = 0;
      for (int c = 0; c < ST + 3; c++) begin
        t = 5'(base + nacc);
        cycle(1'b1, 32'h8000_0001, 32'(t), ROL, t, 1'b0, 1'b0,
              {t, model(32'h8000_0001, 32'(t), ROL)}, acc);
        if (acc) nacc++;
      end
    endtask

    initial begin
      logic acc;
      logic [97:0] d;
      int n, nacc, cnt;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk(ST, "reset_o_valid", 64'(o_valid), 64'd0);
      chk(ST, "reset_o_result", 64'(o_result), 64'd0);
      chk(ST, "reset_o_tag", 64'(o_tag), 64'd0);
      chk(ST, "reset_o_ready", 64'(o_ready), 64'd1);

      // Latency of a lone operation
      d = dvec(0);
      cycle(1'b1, d[97:66], d[65:34], d[33:32], 5'd1, 1'b1, 1'b0, {5'd1, d[31:0]}, acc);
      chk(ST, "first_accept", 64'(acc), 64'd1);
      n = 0;
      while (!o_valid && n < 10) begin idle(1'b1); n++; end
      chk(ST, "latency", 64'(n), 64'(ST - 1));
      drain();

      // Directed vectors back to back
      for (int i = 1; i < NVEC; i++) begin
        d = dvec(i);
        cycle(1'b1, d[97:66], d[65:34], d[33:32], 5'(i + 1), 1'b1, 1'b0, {5'(i + 1), d[31:0]}, acc);
      end
      drain();

      // Backpressure: capacity equals STAGES, output holds stable under stall
      fill(1, nacc);
      chk(ST, "bp_accepts", 64'(nacc), 64'(ST));
      chk(ST, "bp_o_ready_low", 64'(o_ready), 64'd0);
      chk(ST, "bp_hold_valid", 64'(o_valid), 64'd1);
      chk(ST, "bp_hold_result", 64'(o_result), 64'(model(32'h8000_0001, 32'd1, ROL)));
      chk(ST, "bp_hold_tag", 64'(o_tag), 64'd1);
      for (int c = 0; c < 20 && nacc < ST + 2; c++) begin
        logic [4:0] t;
        t = 5'(nacc + 1);
        cycle(1'b1, 32'h8000_0001, 32'(t), ROL, t, 1'b1, 1'b0,
              {t, model(32'h8000_0001, 32'(t), ROL)}, acc);
        if (acc) nacc++;
      end
      chk(ST, "bp_resume_accepts", 64'(nacc), 64'(ST + 2));
      drain();

      // Flush with the pipeline full and a new op presented the same cycle
      fill(10, nacc);
      cycle(1'b1, 32'h1, 32'd2, SLL, 5'd20, 1'b1, 1'b1, {5'd20, 32'h4}, acc);
      cnt = 0;
      for (int c = 0; c < ST + 3; c++) begin
        if (o_valid) cnt++;
        idle(1'b1);
      end
      chk(ST, "flush_quiet", 64'(cnt), 64'd0);
      cycle(1'b1, 32'h1, 32'd3, SLL, 5'd21, 1'b1, 1'b0, {5'd21, 32'h8}, acc);
      drain();

      // Randomized traffic with random backpressure and occasional flush
      for (int i = 0; i < 400; i++) begin
        logic [31:0] a, sh;
        logic [1:0] op;
        logic [4:0] t;
        a  = $urandom;
        sh = $urandom;
        op = 2'($urandom_range(0, 3));
        t  = 5'($urandom);
        cycle($urandom_range(0, 3) != 0, a, sh, op, t, $urandom_range(0, 3) != 0,
              $urandom_range(0, 40) == 0, {t, model(a, sh, op)}, acc);
      end
      drain();

      // Reset with a full, stalled pipeline
      fill(3, nacc);
      chk(ST, "pre_reset_valid", 64'(o_valid), 64'd1);
      rst = 1'b1;
      idle(1'b0);
      rst = 1'b0;
      chk(ST, "midrst_o_valid", 64'(o_valid), 64'd0);
      chk(ST, "midrst_o_result", 64'(o_result), 64'd0);
      chk(ST, "midrst_o_tag", 64'(o_tag), 64'd0);
      chk(ST, "midrst_o_ready", 64'(o_ready), 64'd1);
      cnt = 0;
      for (int c = 0; c < ST + 3; c++) begin
        if (o_valid) cnt++;
        idle(1'b1);
      end
      chk(ST, "midrst_quiet", 64'(cnt), 64'd0);

      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && done_cnt < 3; t++) @(posedge clk);
    if (done_cnt < 3) begin
      checks++;
      failures++;
      $display("FAIL timeout finished=%0d required=3", done_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
